// File: rtl/ir_decoder_pkg.sv
// Shared CPU opcode definitions: byte constants and an enum over the same 29 values,
// for use by the instruction decoder, the controller and assembler tests.
package ir_decoder_pkg;

    localparam int NUM_OPS = 29;

    localparam logic [7:0] OP_LD_A   = 8'h90;
    localparam logic [7:0] OP_LD_B   = 8'h91;
    localparam logic [7:0] OP_ADD_A  = 8'h92;
    localparam logic [7:0] OP_ADD_B  = 8'h93;
    localparam logic [7:0] OP_ADD_AB = 8'h94;
    localparam logic [7:0] OP_ADD_BA = 8'h95;
    localparam logic [7:0] OP_SUB_A  = 8'h96;
    localparam logic [7:0] OP_SUB_B  = 8'h97;
    localparam logic [7:0] OP_SUB_AB = 8'h98;
    localparam logic [7:0] OP_SUB_BA = 8'h99;
    localparam logic [7:0] OP_MUL_A  = 8'h9A;
    localparam logic [7:0] OP_MUL_B  = 8'h9B;
    localparam logic [7:0] OP_MUL_AB = 8'h9C;
    localparam logic [7:0] OP_MUL_BA = 8'h9D;
    localparam logic [7:0] OP_DIV_A  = 8'h9E;
    localparam logic [7:0] OP_DIV_B  = 8'h9F;
    localparam logic [7:0] OP_DIV_AB = 8'hA0;
    localparam logic [7:0] OP_DIV_BA = 8'hA1;
    localparam logic [7:0] OP_SHL_A  = 8'hA2;
    localparam logic [7:0] OP_SHL_B  = 8'hA3;
    localparam logic [7:0] OP_SHL_AB = 8'hA4;
    localparam logic [7:0] OP_SHL_BA = 8'hA5;
    localparam logic [7:0] OP_SHR_A  = 8'hA6;
    localparam logic [7:0] OP_SHR_B  = 8'hA7;
    localparam logic [7:0] OP_SHR_AB = 8'hA8;
    localparam logic [7:0] OP_SHR_BA = 8'hA9;
    localparam logic [7:0] OP_ST     = 8'hC0;
    localparam logic [7:0] OP_JMP    = 8'hC1;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    typedef enum logic [7:0] {
        OPC_LD_A   = OP_LD_A,   OPC_LD_B   = OP_LD_B,
        OPC_ADD_A  = OP_ADD_A,  OPC_ADD_B  = OP_ADD_B,
        OPC_ADD_AB = OP_ADD_AB, OPC_ADD_BA = OP_ADD_BA,
        OPC_SUB_A  = OP_SUB_A,  OPC_SUB_B  = OP_SUB_B,
        OPC_SUB_AB = OP_SUB_AB, OPC_SUB_BA = OP_SUB_BA,
        OPC_MUL_A  = OP_MUL_A,  OPC_MUL_B  = OP_MUL_B,
        OPC_MUL_AB = OP_MUL_AB, OPC_MUL_BA = OP_MUL_BA,
        OPC_DIV_A  = OP_DIV_A,  OPC_DIV_B  = OP_DIV_B,
        OPC_DIV_AB = OP_DIV_AB, OPC_DIV_BA = OP_DIV_BA,
        OPC_SHL_A  = OP_SHL_A,  OPC_SHL_B  = OP_SHL_B,
        OPC_SHL_AB = OP_SHL_AB, OPC_SHL_BA = OP_SHL_BA,
        OPC_SHR_A  = OP_SHR_A,  OPC_SHR_B  = OP_SHR_B,
        OPC_SHR_AB = OP_SHR_AB, OPC_SHR_BA = OP_SHR_BA,
        OPC_ST     = OP_ST,     OPC_JMP    = OP_JMP,
        OPC_HALT   = OP_HALT
    } opcode_e;

endpackage

// File: rtl/ir_decoder.sv
// Instruction register with a one-hot opcode decoder; strobes depend only on the
// registered byte, so a new opcode shows up just after the edge that loads it.
module ir_decoder
    import ir_decoder_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       IIRn,
    input  logic [7:0] Din,
    output logic       LD_A,
    output logic       LD_B,
    output logic       ADD_A,
    output logic       ADD_B,
    output logic       ADD_AB,
    output logic       ADD_BA,
    output logic       SUB_A,
    output logic       SUB_B,
    output logic       SUB_AB,
    output logic       SUB_BA,
    output logic       MUL_A,
    output logic       MUL_B,
    output logic       MUL_AB,
    output logic       MUL_BA,
    output logic       DIV_A,
    output logic       DIV_B,
    output logic       DIV_AB,
    output logic       DIV_BA,
    output logic       SHL_A,
    output logic       SHL_B,
    output logic       SHL_AB,
    output logic       SHL_BA,
    output logic       SHR_A,
    output logic       SHR_B,
    output logic       SHR_AB,
    output logic       SHR_BA,
    output logic       ST,
    output logic       JMP,
    output logic       HALT
);

    logic [7:0]         ir;
    logic [NUM_OPS-1:0] dec;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ir <= 8'h00;
        end else if (!IIRn) begin
            ir <= Din;
        end
    end

    // dec bit i corresponds to the i-th strobe in port order (bit 0 = LD_A).
    always_comb begin
        dec = '0;
        case (ir)
            OP_LD_A:   dec[0]  = 1'b1;
            OP_LD_B:   dec[1]  = 1'b1;
            OP_ADD_A:  dec[2]  = 1'b1;
            OP_ADD_B:  dec[3]  = 1'b1;
            OP_ADD_AB: dec[4]  = 1'b1;
            OP_ADD_BA: dec[5]  = 1'b1;
            OP_SUB_A:  dec[6]  = 1'b1;
            OP_SUB_B:  dec[7]  = 1'b1;
            OP_SUB_AB: dec[8]  = 1'b1;
            OP_SUB_BA: dec[9]  = 1'b1;
            OP_MUL_A:  dec[10] = 1'b1;
            OP_MUL_B:  dec[11] = 1'b1;
            OP_MUL_AB: dec[12] = 1'b1;
            OP_MUL_BA: dec[13] = 1'b1;
            OP_DIV_A:  dec[14] = 1'b1;
            OP_DIV_B:  dec[15] = 1'b1;
            OP_DIV_AB: dec[16] = 1'b1;
            OP_DIV_BA: dec[17] = 1'b1;
            OP_SHL_A:  dec[18] = 1'b1;
            OP_SHL_B:  dec[19] = 1'b1;
            OP_SHL_AB: dec[20] = 1'b1;
            OP_SHL_BA: dec[21] = 1'b1;
            OP_SHR_A:  dec[22] = 1'b1;
            OP_SHR_B:  dec[23] = 1'b1;
            OP_SHR_AB: dec[24] = 1'b1;
            OP_SHR_BA: dec[25] = 1'b1;
            OP_ST:     dec[26] = 1'b1;
            OP_JMP:    dec[27] = 1'b1;
            OP_HALT:   dec[28] = 1'b1;
            default:   dec     = '0;
        endcase
    end

    assign LD_A   = dec[0];
    assign LD_B   = dec[1];
    assign ADD_A  = dec[2];
    assign ADD_B  = dec[3];
    assign ADD_AB = dec[4];
    assign ADD_BA = dec[5];
    assign SUB_A  = dec[6];
    assign SUB_B  = dec[7];
    assign SUB_AB = dec[8];
    assign SUB_BA = dec[9];
    assign MUL_A  = dec[10];
    assign MUL_B  = dec[11];
    assign MUL_AB = dec[12];
    assign MUL_BA = dec[13];
    assign DIV_A  = dec[14];
    assign DIV_B  = dec[15];
    assign DIV_AB = dec[16];
    assign DIV_BA = dec[17];
    assign SHL_A  = dec[18];
    assign SHL_B  = dec[19];
    assign SHL_AB = dec[20];
    assign SHL_BA = dec[21];
    assign SHR_A  = dec[22];
    assign SHR_B  = dec[23];
    assign SHR_AB = dec[24];
    assign SHR_BA = dec[25];
    assign ST     = dec[26];
    assign JMP    = dec[27];
    assign HALT   = dec[28];

endmodule

// File: tb/tb_ir_decoder.sv
// Directed and random checks of the instruction-register decoder against a
// small arithmetic opcode model, using an expected-value queue.
module tb_ir_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       IIRn = 1'b1;
    logic [7:0] Din = 8'h00;
    logic LD_A, LD_B;
    logic ADD_A, ADD_B, ADD_AB, ADD_BA;
    logic SUB_A, SUB_B, SUB_AB, SUB_BA;
    logic MUL_A, MUL_B, MUL_AB, MUL_BA;
    logic DIV_A, DIV_B, DIV_AB, DIV_BA;
    logic SHL_A, SHL_B, SHL_AB, SHL_BA;
    logic SHR_A, SHR_B, SHR_AB, SHR_BA;
    logic ST, JMP, HALT;

    logic [28:0] exp_q[$];
    logic [7:0]  model_ir;
    int          n_checks = 0;
    int          n_pass   = 0;

    ir_decoder dut (
        .CLK(CLK), .RST(RST), .IIRn(IIRn), .Din(Din),
        .LD_A(LD_A), .LD_B(LD_B),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_AB(ADD_AB), .ADD_BA(ADD_BA),
        .SUB_A(SUB_A), .SUB_B(SUB_B), .SUB_AB(SUB_AB), .SUB_BA(SUB_BA),
        .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_AB(MUL_AB), .MUL_BA(MUL_BA),
        .DIV_A(DIV_A), .DIV_B(DIV_B), .DIV_AB(DIV_AB), .DIV_BA(DIV_BA),
        .SHL_A(SHL_A), .SHL_B(SHL_B), .SHL_AB(SHL_AB), .SHL_BA(SHL_BA),
        .SHR_A(SHR_A), .SHR_B(SHR_B), .SHR_AB(SHR_AB), .SHR_BA(SHR_BA),
        .ST(ST), .JMP(JMP), .HALT(HALT)
    );

    // 20 ns clock
    always #10 CLK = ~CLK;

    function automatic logic [28:0] outs();
        return {HALT, JMP, ST,
                SHR_BA, SHR_AB, SHR_B, SHR_A, SHL_BA, SHL_AB, SHL_B, SHL_A,
                DIV_BA, DIV_AB, DIV_B, DIV_A, MUL_BA, MUL_AB, MUL_B, MUL_A,
                SUB_BA, SUB_AB, SUB_B, SUB_A, ADD_BA, ADD_AB, ADD_B, ADD_A,
                LD_B, LD_A};
    endfunction

    // Opcode map: 0x90..0xA9 are consecutive strobes, then ST, JMP, HALT.
    function automatic logic [28:0] model_dec(input logic [7:0] op);
        logic [28:0] v;
        int          idx;
        v   = '0;
        idx = int'(op);
        if (idx >= 'h90 && idx <= 'hA9) v[idx - 'h90] = 1'b1;
        else if (idx == 'hC0) v[26] = 1'b1;
        else if (idx == 'hC1) v[27] = 1'b1;
        else if (idx == 'hFF) v[28] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag);
        logic [28:0] obs;
        logic [28:0] exp_v;
        obs = outs();
        n_checks++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h, expected queue empty", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic step(input logic iirn, input logic [7:0] din, input string tag);
        IIRn = iirn;
        Din  = din;
        if (!iirn) model_ir = din;
        exp_q.push_back(model_dec(model_ir));
        @(posedge CLK);
        #1;
        check(tag);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        model_ir = 8'h00;
        #3;
        exp_q.push_back(model_dec(model_ir));
        check("reset_async");
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    logic [7:0] op;
    logic [7:0] unmapped_tab[5];

    initial begin
        model_ir = 8'h00;
        unmapped_tab[0] = 8'h00; unmapped_tab[1] = 8'h8F; unmapped_tab[2] = 8'hAA;
        unmapped_tab[3] = 8'hC2; unmapped_tab[4] = 8'hFE;

        // Reset, then a held register ignores Din.
        #2;
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h90, "hold_after_reset");

        // Reset dominates a pending load.
        RST = 1'b1;
        IIRn = 1'b0;
        Din = 8'h90;
        @(posedge CLK);
        #1;
        exp_q.push_back(model_dec(8'h00));
        check("rst_dominates_load");
        RST = 1'b0;

        // Walk every mapped opcode: load edge then a hold edge.
        for (int i = 0; i < 26; i++) begin
            op = 8'h90 + 8'(i);
            step(1'b0, op, "walk_load");
            step(1'b1, 8'h00, "walk_hold");
        end
        step(1'b0, 8'hC0, "st_load");
        step(1'b1, 8'h00, "st_hold");
        step(1'b0, 8'hC1, "jmp_load");
        step(1'b1, 8'h00, "jmp_hold");
        step(1'b0, 8'hFF, "halt_load");
        for (int i = 0; i < 3; i++) step(1'b1, 8'h12, "halt_stays");

        // Hold keeps ADD_BA while Din shows SUB_A.
        step(1'b0, 8'h95, "add_ba_load");
        step(1'b1, 8'h96, "add_ba_hold");
        step(1'b1, 8'h96, "add_ba_hold2");

        // Unmapped values clear every strobe.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h92, "pre_unmapped");
            step(1'b0, unmapped_tab[i], "unmapped");
        end

        // Same opcode loaded on consecutive edges; probe mid-cycle too.
        step(1'b0, 8'h93, "add_b_first");
        step(1'b0, 8'h93, "add_b_second");
        #9;
        exp_q.push_back(model_dec(8'h93));
        check("add_b_midcycle");
        step(1'b0, 8'h93, "add_b_third");

        // Async reset between edges drops HALT before the next edge.
        step(1'b0, 8'hFF, "halt_before_rst");
        IIRn = 1'b1;
        #4;
        pulse_reset();
        step(1'b1, 8'hC0, "hold_after_rst");
        step(1'b0, 8'hC0, "load_after_rst");

        // Random loads and holds.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) op = 8'($urandom_range(8'h8E, 8'hAB));
            else op = 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 2) == 0), op, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $error("FAIL timeout: observed running, expected finished");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
